// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: synchronises start/cmp, walks a trial
// code MSB-first through the DAC and publishes the final code with a valid strobe.
module sar_adc_ctrl #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             cmp,
  output logic [WIDTH-1:0] dac_code,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             busy
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(SETTLE_CYCLES + 2);
  // Settle phase lasts SETTLE_CYCLES+2 cycles: counter runs from this value down to 0.
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES + 1);
  localparam logic [IW-1:0] IDX_TOP  = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, DECIDE, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] trial, trial_n, dac_n, result_n, trial_first, trial_dec;
  logic [IW-1:0]    idx, idx_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             valid_n, busy_n;
  logic             start_s1, sync_start, start_q, cmp_s1, sync_cmp, start_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_s1   <= 1'b0;
      sync_start <= 1'b0;
      start_q    <= 1'b0;
      cmp_s1     <= 1'b0;
      sync_cmp   <= 1'b0;
    end else begin
      start_s1   <= start;
      sync_start <= start_s1;
      start_q    <= sync_start;
      cmp_s1     <= cmp;
      sync_cmp   <= cmp_s1;
    end
  end

  assign start_rise = sync_start & ~start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      trial    <= '0;
      idx      <= '0;
      cnt      <= '0;
      dac_code <= '0;
      result   <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      trial    <= trial_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      dac_code <= dac_n;
      result   <= result_n;
      valid    <= valid_n;
      busy     <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    trial_n  = trial;
    idx_n    = idx;
    cnt_n    = cnt;
    dac_n    = dac_code;
    result_n = result;
    valid_n  = 1'b0;
    busy_n   = busy;

    trial_first              = '0;
    trial_first[WIDTH-1]     = 1'b1;
    trial_dec                = trial;
    if (!sync_cmp) trial_dec[idx] = 1'b0;
    if (idx != '0) trial_dec[idx - IW'(1)] = 1'b1;

    case (state)
      IDLE: begin
        if (start_rise) begin
          state_n = SETTLE;
          trial_n = trial_first;
          dac_n   = trial_first;
          idx_n   = IDX_TOP;
          cnt_n   = CNT_LOAD;
          busy_n  = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt == '0) state_n = DECIDE;
        else           cnt_n   = cnt - CW'(1);
      end
      DECIDE: begin
        trial_n = trial_dec;
        dac_n   = trial_dec;
        if (idx != '0) begin
          idx_n   = idx - IW'(1);
          cnt_n   = CNT_LOAD;
          state_n = SETTLE;
        end else begin
          result_n = trial_dec;
          valid_n  = 1'b1;
          busy_n   = 1'b0;
          state_n  = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Disable overrides everything; result is kept so the last good code survives.
    if (!ena) begin
      state_n  = IDLE;
      dac_n    = '0;
      busy_n   = 1'b0;
      valid_n  = 1'b0;
      result_n = result;
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl: default build plus a SETTLE_CYCLES=0 build,
// both converting a behavioural comparator input vin.
module tb_sar_adc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, ena, start;
  logic [3:0] vin;
  logic       cmp_a, cmp_b, valid_a, valid_b, busy_a, busy_b;
  logic [3:0] dac_a, res_a, dac_b, res_b;

  always #5 clk = ~clk;

  assign cmp_a = (vin >= dac_a);
  assign cmp_b = (vin >= dac_b);

  sar_adc_ctrl #(.WIDTH(4), .SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .cmp(cmp_a),
    .dac_code(dac_a), .result(res_a), .valid(valid_a), .busy(busy_a)
  );

  sar_adc_ctrl #(.WIDTH(4), .SETTLE_CYCLES(0)) u_dut_fast (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .cmp(cmp_b),
    .dac_code(dac_b), .result(res_b), .valid(valid_b), .busy(busy_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] dac_log[$];
  int         lat_a, lat_b, nv_a, nv_b, busy_at;
  int         r_a, r_b;

  // Start is driven just after edge 0; cycle k is the k-th edge after that.
  // Two synchroniser edges plus the edge register put the captured start_rise at edge 3.
  task automatic run_conv(input logic [3:0] v, input int cycles);
    logic [3:0] last;
    vin = v; lat_a = -1; lat_b = -1; nv_a = 0; nv_b = 0; busy_at = -1;
    r_a = -1; r_b = -1;
    dac_log.delete();
    last  = dac_a;
    start = 1'b1;
    for (int k = 1; k <= cycles; k++) begin
      tick();
      if (busy_a && busy_at < 0) busy_at = k;
      if (dac_a != last) begin dac_log.push_back(dac_a); last = dac_a; end
      if (valid_a) begin nv_a++; lat_a = k; r_a = int'(res_a); end
      if (valid_b) begin nv_b++; lat_b = k; r_b = int'(res_b); end
    end
    start = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int cnt_v, bad;
    rst_n = 1'b0; ena = 1'b1; start = 1'b1; vin = 4'd15;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_dac",    int'(dac_a),   0);
    check_eq("rst_result", int'(res_a),   0);
    check_eq("rst_valid",  int'(valid_a), 0);
    check_eq("rst_busy",   int'(busy_a),  0);
    start = 1'b0;
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if ((dac_a != 0) || (res_a != 0) || valid_a || busy_a) bad++;
    end
    check_eq("post_reset_quiet", bad, 0);

    // Vin = 11: trial codes 1000, 1100, 1010, 1011
    run_conv(4'd11, 40);
    check_eq("c11_result",   r_a, 11);
    check_eq("c11_nvalid",   nv_a, 1);
    check_eq("c11_latency",  lat_a, 23);
    check_eq("c11_busy_at",  busy_at, 3);
    check_eq("c11_nsteps",   dac_log.size(), 4);
    if (dac_log.size() == 4) begin
      check_eq("c11_step0", int'(dac_log[0]), 8);
      check_eq("c11_step1", int'(dac_log[1]), 12);
      check_eq("c11_step2", int'(dac_log[2]), 10);
      check_eq("c11_step3", int'(dac_log[3]), 11);
    end
    check_eq("c11_idle_busy", int'(busy_a), 0);
    check_eq("c11_dac_hold",  int'(dac_a), 11);
    check_eq("fast_result",   r_b, 11);
    check_eq("fast_latency",  lat_b, 15);

    for (int v = 0; v < 16; v++) begin
      run_conv(4'(v), 30);
      check_eq($sformatf("sweep%0d_a", v), r_a, v);
      check_eq($sformatf("sweep%0d_b", v), r_b, v);
      check_eq($sformatf("sweep%0d_nv", v), nv_a, 1);
    end

    // Start held high for 100 cycles
    vin = 4'd9; start = 1'b1; cnt_v = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (valid_a) cnt_v++;
    end
    start = 1'b0;
    repeat (4) tick();
    check_eq("held_nvalid", cnt_v, 1);
    check_eq("held_result", int'(res_a), 9);

    // Second rising edge while busy must be ignored
    vin = 4'd5; start = 1'b1; cnt_v = 0; lat_a = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 8)  start = 1'b0;
      if (k == 11) start = 1'b1;
      tick();
      if (valid_a) begin cnt_v++; lat_a = k; end
    end
    start = 1'b0;
    repeat (4) tick();
    check_eq("reedge_nvalid",  cnt_v, 1);
    check_eq("reedge_result",  int'(res_a), 5);
    check_eq("reedge_latency", lat_a, 23);

    // ena dropped seven cycles into a conversion
    vin = 4'd11; start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (busy_a) break;
      tick();
    end
    check_eq("abort_started", int'(busy_a), 1);
    repeat (7) tick();
    ena = 1'b0;
    tick();
    check_eq("abort_busy", int'(busy_a), 0);
    check_eq("abort_dac",  int'(dac_a),  0);
    cnt_v = 0; bad = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (valid_a) cnt_v++;
      if (busy_a) bad++;
    end
    check_eq("abort_nvalid", cnt_v, 0);
    check_eq("abort_stays_idle", bad, 0);
    check_eq("abort_result", int'(res_a), 5);
    start = 1'b0; ena = 1'b1;
    repeat (4) tick();
    run_conv(4'd6, 30);
    check_eq("restart_result", r_a, 6);
    check_eq("restart_nvalid", nv_a, 1);

    // Asynchronous reset mid-conversion
    vin = 4'd13; start = 1'b1;
    repeat (10) tick();
    check_eq("mid_busy_before", int'(busy_a), 1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy",   int'(busy_a),  0);
    check_eq("arst_dac",    int'(dac_a),   0);
    check_eq("arst_result", int'(res_a),   0);
    check_eq("arst_valid",  int'(valid_a), 0);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    rst_n = 1'b1;
    cnt_v = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (valid_a) cnt_v++;
    end
    check_eq("arst_nvalid", cnt_v, 0);
    run_conv(4'd11, 40);
    check_eq("post_arst_result", r_a, 11);
    check_eq("post_arst_fast",   r_b, 11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
